cnn_layer_sequencer: RTL and testbench

- Controller that sequences one single-layer convolution job through the CNN datapath (multiplier → 15-word partial-sum register file → 3-input adder).
- Accepts a job, streams 15 image/filter pairs into the datapath with Start, then issues 5 ReadEn cycles and returns 5 convolution results over a valid/ready stream.
- Sits between the input buffers and the CNN_Single_Layer instance; owns Start and ReadEn exclusively.

---
 rtl/cnn_layer_sequencer_if.sv | 31 +++
 rtl/cnn_layer_sequencer.sv | 98 +++++++++
 tb/tb_cnn_layer_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cnn_layer_sequencer_if.sv
// cnn_layer_sequencer_if: job, input-pair, datapath and result-stream signals of the sequencer
interface cnn_layer_sequencer_if #(
  parameter int DW = 4,
  parameter int RW = 10
);
  logic          job_req;
  logic          job_ack;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] img_in;
  logic [DW-1:0] flt_in;
  logic          Start;
  logic [DW-1:0] Image;
  logic [DW-1:0] Filter;
  logic          ReadEn;
  logic [RW-1:0] ConvResult;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_data;
  logic          busy;
  logic          done;
  logic [15:0]   perf_cycles;
  modport master (
    input  job_req, in_valid, img_in, flt_in, ConvResult, res_ready,
    output job_ack, in_ready, Start, Image, Filter, ReadEn, res_valid, res_data, busy, done, perf_cycles
  );
  modport slave (
    output job_req, in_valid, img_in, flt_in, ConvResult, res_ready,
    input  job_ack, in_ready, Start, Image, Filter, ReadEn, res_valid, res_data, busy, done, perf_cycles
  );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: sequences one convolution job (NUM_MAC Start pairs, NUM_OUT ReadEn/results).
// Optional cycle counter on perf_cycles enabled by defining CNN_SEQ_PERF_EN.
module cnn_layer_sequencer #(
  parameter int NUM_MAC = 15,
  parameter int NUM_OUT = 5,
  parameter int ADD_LAT = 1,
  parameter int DW      = 4,
  parameter int RW      = 10
) (
  input logic clk,
  input logic rst_n,
  cnn_layer_sequencer_if.master bus
);
  localparam int MW = $clog2(NUM_MAC + 1);
  localparam int OW = $clog2(NUM_OUT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} stateT;
  stateT        state, nextState;
  logic [MW-1:0] macCnt;
  logic [OW-1:0] rdCnt, accCnt;
  logic [ADD_LAT-1:0] vldSr;
  logic [RW-1:0] fifoMem [2];
  logic          wrPtr, rdPtr;
  logic [1:0]    fifoCnt;
  logic [7:0]    inFlight;
  logic jobAck, accept, readEn, push, pop, issueOk, lastPair, lastIssue, lastPop;
  always_ff @(posedge clk)
    if (rst_n) state <= IDLE;
    else       state <= nextState;
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = bus.job_req ? LOAD  : IDLE;
      LOAD:    nextState = lastPair    ? READ  : LOAD;
      READ:    nextState = lastIssue   ? DRAIN : READ;
      default: nextState = lastPop     ? IDLE  : DRAIN;
    endcase
  end
  always_comb begin
    inFlight = '0;
    for (int i = 0; i < ADD_LAT; i++) inFlight = inFlight + 8'(vldSr[i]);
  end
  // A pop this cycle frees a slot, so back-to-back issue is possible while the consumer keeps up
  assign push      = vldSr[ADD_LAT-1];
  assign pop       = (fifoCnt != 2'd0) && bus.res_ready;
  assign issueOk   = (inFlight + 8'(fifoCnt)) < (8'd2 + 8'(pop));
  assign jobAck    = (state == IDLE) && bus.job_req;
  assign accept    = (state == LOAD) && bus.in_valid;
  assign readEn    = (state == READ) && (rdCnt != OW'(NUM_OUT)) && issueOk;
  assign lastPair  = accept && (macCnt == MW'(NUM_MAC - 1));
  assign lastIssue = readEn && (rdCnt == OW'(NUM_OUT - 1));
  assign lastPop   = (state == DRAIN) && pop && (accCnt == OW'(NUM_OUT - 1));
  always_comb begin
    bus.job_ack   = jobAck;
    bus.in_ready  = state == LOAD;
    bus.Start     = accept;
    bus.Image     = accept ? bus.img_in : '0;
    bus.Filter    = accept ? bus.flt_in : '0;
    bus.ReadEn    = readEn;
    bus.res_valid = fifoCnt != 2'd0;
    bus.res_data  = fifoMem[rdPtr];
    bus.busy      = state != IDLE;
    bus.done      = lastPop;
  end
  always_ff @(posedge clk)
    if (rst_n) begin
      macCnt <= '0;
      rdCnt  <= '0;
      accCnt <= '0;
      vldSr  <= '0;
    end else begin
      macCnt <= jobAck ? '0 : (accept && macCnt != MW'(NUM_MAC)) ? macCnt + 1'b1 : macCnt;
      rdCnt  <= jobAck ? '0 : (readEn && rdCnt != OW'(NUM_OUT)) ? rdCnt + 1'b1 : rdCnt;
      accCnt <= jobAck ? '0 : (pop && accCnt != OW'(NUM_OUT)) ? accCnt + 1'b1 : accCnt;
      vldSr  <= ADD_LAT'({vldSr, readEn});
    end
  always_ff @(posedge clk)
    if (rst_n) begin
      fifoMem <= '{default: '0};
      wrPtr   <= 1'b0;
      rdPtr   <= 1'b0;
      fifoCnt <= 2'd0;
    end else begin
      if (push) fifoMem[wrPtr] <= bus.ConvResult;
      wrPtr   <= wrPtr ^ push;
      rdPtr   <= rdPtr ^ pop;
      fifoCnt <= fifoCnt + 2'(push) - 2'(pop);
    end
`ifdef CNN_SEQ_PERF_EN
  logic [15:0] perfCnt;
  always_ff @(posedge clk)
    if (rst_n)                                       perfCnt <= '0;
    else if (jobAck)                                 perfCnt <= 16'd1;
    else if (state != IDLE && perfCnt != 16'hFFFF)   perfCnt <= perfCnt + 16'd1;
  assign bus.perf_cycles = perfCnt;
`else
  assign bus.perf_cycles = '0;
`endif
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: directed jobs against a behavioural multiplier/register-file/adder datapath
module tb_cnn_layer_sequencer;
  localparam int DW = 4;
  localparam int RW = 10;
`ifdef CNN_SEQ_PERF_EN
  localparam int PERF_EXP = 23;
`else
  localparam int PERF_EXP = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  cnn_layer_sequencer_if #(.DW(DW), .RW(RW)) bus ();
  cnn_layer_sequencer #(.DW(DW), .RW(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  // datapath: product stored per Start, 3-word sum registered one cycle after ReadEn
  logic [7:0] rf [15];
  int wa = 0, ra = 0;
  always @(posedge clk)
    if (rst_n) begin
      wa <= 0;
      ra <= 0;
      bus.ConvResult <= '0;
    end else begin
      if (bus.Start) begin
        rf[wa] <= 8'(bus.Image * bus.Filter);
        wa <= (wa == 14) ? 0 : wa + 1;
      end
      if (bus.ReadEn) begin
        bus.ConvResult <= RW'(rf[3*ra]) + RW'(rf[3*ra+1]) + RW'(rf[3*ra+2]);
        ra <= (ra == 4) ? 0 : ra + 1;
      end
    end
  int cyc = 0, ackCyc = 0, doneCyc = 0, starts = 0, readEns = 0, acks = 0, dones = 0;
  int overlap = 0, badStart = 0, badPass = 0;
  int resQ [$];
  always @(negedge clk) begin
    cyc++;
    if (bus.job_ack) begin acks++; ackCyc = cyc; end
    if (bus.done) begin dones++; doneCyc = cyc; end
    if (bus.Start) starts++;
    if (bus.ReadEn) readEns++;
    if (bus.Start && bus.ReadEn) overlap++;
    if (bus.Start && !bus.in_valid) badStart++;
    if (bus.Start && (bus.Image !== bus.img_in || bus.Filter !== bus.flt_in)) badPass++;
    if (bus.res_valid && bus.res_ready) resQ.push_back(int'(bus.res_data));
  end
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic checkIdle(input string nm);
    check({nm, "_ack"}, 32'(bus.job_ack), 0);
    check({nm, "_rdy"}, 32'(bus.in_ready), 0);
    check({nm, "_start"}, 32'(bus.Start), 0);
    check({nm, "_img"}, 32'(bus.Image), 0);
    check({nm, "_flt"}, 32'(bus.Filter), 0);
    check({nm, "_rden"}, 32'(bus.ReadEn), 0);
    check({nm, "_rval"}, 32'(bus.res_valid), 0);
    check({nm, "_rdata"}, 32'(bus.res_data), 0);
    check({nm, "_busy"}, 32'(bus.busy), 0);
    check({nm, "_done"}, 32'(bus.done), 0);
    check({nm, "_perf"}, 32'(bus.perf_cycles), 0);
  endtask
  task automatic runJob(input string nm, input bit alt, input bit stall, input bit poke);
    int expv [5] = '{6, 15, 24, 33, 42};
    int s0, r0, q0, a0, d0, k, guard, rs;
    bit ph, acc;
    s0 = starts; r0 = readEns; q0 = resQ.size(); a0 = acks; d0 = dones;
    @(posedge clk) #1 bus.job_req = 1'b1;
    @(negedge clk) check({nm, "_ack"}, 32'(bus.job_ack), 1);
    @(posedge clk) #1 bus.job_req = 1'b0;
    k = 0; guard = 0; ph = 1'b1;
    while (k < 15 && guard < 100) begin
      bus.in_valid = alt ? ph : 1'b1;
      bus.img_in = DW'(k + 1);
      bus.flt_in = DW'(1);
      bus.job_req = poke && (k == 5);
      @(negedge clk) acc = bus.in_valid && bus.in_ready;
      @(posedge clk) #1;
      if (acc) k++;
      ph = !ph;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.job_req = 1'b0;
    check({nm, "_loaded"}, 32'(k), 15);
    if (stall) begin
      bus.res_ready = 1'b0;
      rs = readEns;
      repeat (10) @(negedge clk);
      check({nm, "_stall_rden"}, 32'(readEns - rs <= 2), 1);
      check({nm, "_stall_valid"}, 32'(bus.res_valid), 1);
      @(posedge clk) #1 bus.res_ready = 1'b1;
    end
    guard = 0;
    while (dones == d0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check({nm, "_done"}, 32'(dones - d0), 1);
    check({nm, "_starts"}, 32'(starts - s0), 15);
    check({nm, "_readens"}, 32'(readEns - r0), 5);
    check({nm, "_acks"}, 32'(acks - a0), 1);
    check({nm, "_nres"}, 32'(resQ.size() - q0), 5);
    for (int i = 0; i < 5; i++)
      if (q0 + i < resQ.size()) check($sformatf("%s_res%0d", nm, i), 32'(resQ[q0+i]), 32'(expv[i]));
    check({nm, "_busy_end"}, 32'(bus.busy), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.job_req = 1'b0;
    bus.in_valid = 1'b0;
    bus.img_in = '0;
    bus.flt_in = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk) checkIdle("rst");
    runJob("basic", 1'b0, 1'b0, 1'b0);
    check("basic_latency", 32'(doneCyc - ackCyc), 22);
    check("basic_perf", 32'(bus.perf_cycles), 32'(PERF_EXP));
    runJob("gapped", 1'b1, 1'b0, 1'b0);
    runJob("stall", 1'b0, 1'b1, 1'b0);
    runJob("poke", 1'b0, 1'b0, 1'b1);
    @(posedge clk) #1 bus.job_req = 1'b1;
    @(posedge clk) #1 bus.job_req = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus.in_valid = 1'b1;
      bus.img_in = DW'(k + 1);
      bus.flt_in = DW'(1);
      @(posedge clk) #1;
    end
    bus.img_in = DW'(8);
    rst_n = 1'b1;
    @(posedge clk) #1 rst_n = 1'b0;
    @(negedge clk) checkIdle("abort");
    @(posedge clk) #1 bus.in_valid = 1'b0;
    runJob("after_abort", 1'b0, 1'b0, 1'b0);
    check("start_readen_overlap", 32'(overlap), 0);
    check("start_without_valid", 32'(badStart), 0);
    check("passthrough", 32'(badPass), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
